irq_ctrl: RTL



---
 rtl/irq_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: four-line edge/level interrupt controller with a single-cycle bus slave
// exposing pending, mask, mode and raw registers.
module irq_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic [3:0]  src_i,
   output logic [3:0]  irq,
   input  logic [3:0]  irqack,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [31:0] adr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o
);
   typedef enum logic {IDLE, BUSY} state_e;
   state_e      state_q;
   logic [3:0]  sync_q [SYNC_STAGES];
   logic [3:0]  prev_q, iack_q, pend_q, pend_d, mask_q, mask_d, irq_q;
   logic [7:0]  mode_q, mode_d, rdata;
   logic [3:0]  act, evt, sw_set, sw_clr;
   logic [31:0] dat_q;
   logic [1:0]  reg_sel;
   logic        ack_q, fire, wr;
   logic        unused;

   assign unused = ^{adr_i[31:4], adr_i[1:0], sel_i[3:1], dat_i[31:8]};
   assign irq    = irq_q;
   assign dat_o  = dat_q;
   assign ack_o  = ack_q;

   always_comb begin
      reg_sel = adr_i[3:2];
      fire    = stb_i && state_q == IDLE;
      wr      = fire && we_i && sel_i[0];
      act     = sync_q[SYNC_STAGES-1] ^ mode_q[7:4];
      // edge-mode lines need the previous level low; level-mode lines fire whenever active
      evt     = act & ~(mode_q[3:0] & prev_q);
      sw_set  = (wr && reg_sel == 2'd3) ? dat_i[3:0] : 4'h0;
      sw_clr  = (wr && reg_sel == 2'd0) ? dat_i[3:0] : 4'h0;
      pend_d  = (pend_q & ~(sw_clr | (irqack & ~iack_q))) | evt | sw_set;
      mask_d  = (wr && reg_sel == 2'd1) ? dat_i[3:0] : mask_q;
      mode_d  = (wr && reg_sel == 2'd2) ? dat_i[7:0] : mode_q;
      rdata   = reg_sel == 2'd0 ? {4'h0, pend_q} :
                reg_sel == 2'd1 ? {4'h0, mask_q} :
                reg_sel == 2'd2 ? mode_q : {4'h0, sync_q[SYNC_STAGES-1]};
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'h0;
         prev_q  <= 4'h0;
         iack_q  <= 4'h0;
         pend_q  <= 4'h0;
         mask_q  <= 4'h0;
         mode_q  <= 8'h0;
         irq_q   <= 4'h0;
         ack_q   <= 1'b0;
         dat_q   <= 32'h0;
         state_q <= IDLE;
      end else begin
         sync_q[0] <= src_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q  <= act;
         iack_q  <= irqack;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         mode_q  <= mode_d;
         irq_q   <= pend_q & mask_q;
         ack_q   <= fire;
         if (fire && !we_i) dat_q <= {24'h0, rdata};
         state_q <= fire ? BUSY : stb_i ? state_q : IDLE;
      end
   end
endmodule
